// File: rtl/armleosoc_axi_bram_if.sv
`default_nettype none
// ============================================================================
// Module   : armleosoc_axi_bram_if
// Purpose  : AXI4 bus bundle between the arbiter host port and the BRAM slave.
// Revision : 1.0 - initial release
// ============================================================================
interface armleosoc_axi_bram_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [ID_WIDTH-1:0]     awid;

    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;

    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic [ID_WIDTH-1:0]     bid;

    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic [ID_WIDTH-1:0]     arid;

    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic [ID_WIDTH-1:0]     rid;
    logic                    rlast;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arlen, arsize, arburst, arid,
        input  arready,
        input  rvalid, rdata, rresp, rid, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arlen, arsize, arburst, arid,
        output arready,
        output rvalid, rdata, rresp, rid, rlast,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/armleosoc_axi_bram.sv
`default_nettype none
// ============================================================================
// Module   : armleosoc_axi_bram
// Purpose  : AXI4 slave over a single-port word RAM; one burst at a time.
// Revision : 1.0 - initial release
// ============================================================================
module armleosoc_axi_bram #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    armleosoc_axi_bram_if.slave axi
);
    localparam int                    c_BYTES  = DATA_WIDTH / 8;
    localparam int                    c_LSB    = $clog2(c_BYTES);
    localparam int                    c_IDX_W  = $clog2(DEPTH);
    localparam logic [2:0]            c_SIZE   = 3'(c_LSB);
    localparam logic [ADDR_WIDTH-1:0] c_ONE    = ADDR_WIDTH'(1);
    localparam logic [1:0]            c_FIXED  = 2'd0;
    localparam logic [1:0]            c_WRAP   = 2'd2;
    localparam logic [1:0]            c_OKAY   = 2'd0;
    localparam logic [1:0]            c_SLVERR = 2'd2;
    localparam logic [1:0]            c_DECERR = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_WRESP  = 3'd2,
        S_RFETCH = 3'd3,
        S_RDATA  = 3'd4
    } state_t;

    state_t                  state_q;
    logic                    last_was_write_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   mask_q;
    logic [7:0]              cnt_q;
    logic [1:0]              burst_q;
    logic [1:0]              err_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic                    wready_q;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;
    logic                    rvalid_q;
    logic [1:0]              rresp_q;
    logic                    rlast_q;
    logic [DATA_WIDTH-1:0]   rd_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    w_pick_write;
    logic                    w_pick_read;
    logic [ADDR_WIDTH-1:0]   w_req_addr;
    logic [7:0]              w_req_len;
    logic [2:0]              w_req_size;
    logic [1:0]              w_req_burst;
    logic [ID_WIDTH-1:0]     w_req_id;
    logic                    w_req_bad;
    logic [ADDR_WIDTH-1:0]   w_req_mask;
    logic [ADDR_WIDTH-1:0]   w_offset;
    logic                    w_in_range;
    logic [c_IDX_W-1:0]      w_idx;
    logic [ADDR_WIDTH-1:0]   w_incr;
    logic [ADDR_WIDTH-1:0]   w_next_addr;
    logic [1:0]              w_beat_resp;
    logic                    w_wlast_bad;
    logic [1:0]              w_wbeat_resp;

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // On a tie the channel not served last time wins.
    assign w_pick_write = axi.awvalid && (!axi.arvalid || !last_was_write_q);
    assign w_pick_read  = axi.arvalid && !w_pick_write;
    assign axi.awready  = rst_n && (state_q == S_IDLE) && w_pick_write;
    assign axi.arready  = rst_n && (state_q == S_IDLE) && w_pick_read;

    assign w_req_addr  = w_pick_write ? axi.awaddr  : axi.araddr;
    assign w_req_len   = w_pick_write ? axi.awlen   : axi.arlen;
    assign w_req_size  = w_pick_write ? axi.awsize  : axi.arsize;
    assign w_req_burst = w_pick_write ? axi.awburst : axi.arburst;
    assign w_req_id    = w_pick_write ? axi.awid    : axi.arid;
    assign w_req_bad   = (w_req_size != c_SIZE) || (w_req_burst == 2'd3) ||
                         ((w_req_burst == c_WRAP) &&
                          !(w_req_len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    assign w_req_mask  = ((ADDR_WIDTH'(w_req_len) + c_ONE) << c_LSB) - c_ONE;

    // Offsets below BASE_ADDR wrap to huge values and fail the same check.
    assign w_offset    = addr_q - BASE_ADDR;
    assign w_in_range  = (w_offset >> (c_LSB + c_IDX_W)) == '0;
    assign w_idx       = w_offset[c_LSB +: c_IDX_W];
    assign w_beat_resp = w_in_range ? err_q : c_DECERR;
    assign w_wlast_bad = axi.wlast != (cnt_q == 8'd0);
    assign w_wbeat_resp = worst(w_beat_resp, w_wlast_bad ? c_SLVERR : c_OKAY);

    always_comb begin
        w_incr = addr_q + ADDR_WIDTH'(c_BYTES);
        case (burst_q)
            c_FIXED: w_next_addr = addr_q;
            c_WRAP:  w_next_addr = (addr_q & ~mask_q) | (w_incr & mask_q);
            default: w_next_addr = w_incr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            last_was_write_q <= 1'b0;
            addr_q           <= '0;
            mask_q           <= '0;
            cnt_q            <= '0;
            burst_q          <= '0;
            err_q            <= c_OKAY;
            id_q             <= '0;
            wready_q         <= 1'b0;
            bvalid_q         <= 1'b0;
            bresp_q          <= c_OKAY;
            rvalid_q         <= 1'b0;
            rresp_q          <= c_OKAY;
            rlast_q          <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_pick_write || w_pick_read) begin
                        addr_q   <= w_req_addr;
                        mask_q   <= w_req_mask;
                        cnt_q    <= w_req_len;
                        burst_q  <= w_req_burst;
                        id_q     <= w_req_id;
                        err_q    <= w_req_bad ? c_SLVERR : c_OKAY;
                        bresp_q  <= w_req_bad ? c_SLVERR : c_OKAY;
                        wready_q <= w_pick_write;
                        state_q  <= w_pick_write ? S_WDATA : S_RFETCH;
                    end
                end
                S_WDATA: begin
                    if (axi.wvalid) begin
                        bresp_q <= worst(bresp_q, w_wbeat_resp);
                        addr_q  <= w_next_addr;
                        cnt_q   <= cnt_q - 8'd1;
                        if (cnt_q == 8'd0) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            state_q  <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (axi.bready) begin
                        bvalid_q         <= 1'b0;
                        last_was_write_q <= 1'b1;
                        state_q          <= S_IDLE;
                    end
                end
                S_RFETCH: begin
                    rresp_q  <= w_beat_resp;
                    rlast_q  <= (cnt_q == 8'd0);
                    rvalid_q <= 1'b1;
                    state_q  <= S_RDATA;
                end
                S_RDATA: begin
                    if (axi.rready) begin
                        rvalid_q <= 1'b0;
                        if (rlast_q) begin
                            last_was_write_q <= 1'b0;
                            state_q          <= S_IDLE;
                        end else begin
                            addr_q  <= w_next_addr;
                            cnt_q   <= cnt_q - 8'd1;
                            state_q <= S_RFETCH;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Storage is not reset; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == S_WDATA) && axi.wvalid && (err_q == c_OKAY) && w_in_range) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (axi.wstrb[b]) begin
                    mem_q[w_idx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
                end
            end
        end
        if (state_q == S_RFETCH) begin
            rd_q <= mem_q[w_idx];
        end
    end

    assign axi.wready = wready_q;
    assign axi.bvalid = bvalid_q;
    assign axi.bresp  = bresp_q;
    assign axi.bid    = id_q;
    assign axi.rvalid = rvalid_q;
    assign axi.rresp  = rresp_q;
    assign axi.rlast  = rlast_q;
    assign axi.rid    = id_q;
    assign axi.rdata  = (rvalid_q && (rresp_q == c_OKAY)) ? rd_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_armleosoc_axi_bram.sv
`default_nettype none
// ============================================================================
// Module   : tb_armleosoc_axi_bram
// Purpose  : Directed self-checking bench for the AXI4 BRAM slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_armleosoc_axi_bram;
    localparam logic [1:0] c_FIXED = 2'd0;
    localparam logic [1:0] c_INCR  = 2'd1;
    localparam logic [1:0] c_WRAP  = 2'd2;
    localparam int         c_LIMIT = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] wd  [16];
    logic [3:0]  ws  [16];
    logic        wl  [16];
    logic [31:0] rdv [16];
    logic [1:0]  rrv [16];
    logic        rlv [16];
    logic [3:0]  rid_v;
    logic [1:0]  bresp_v;
    logic [3:0]  bid_v;
    int          b_wait;
    int          r_wait;

    armleosoc_axi_bram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) axi ();

    armleosoc_axi_bram #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .DEPTH(1024), .BASE_ADDR(32'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .axi   (axi)
    );

    always #5 clk = ~clk;

    logic [17:0] ctl_outs;
    assign ctl_outs = {axi.awready, axi.arready, axi.wready, axi.bvalid, axi.bresp, axi.bid,
                       axi.rvalid, axi.rresp, axi.rid, axi.rlast};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            wd[i] = base + 32'(i);
            ws[i] = 4'hF;
            wl[i] = (i == n - 1);
        end
    endtask

    task automatic set_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bt, input logic [3:0] id);
        axi.awaddr = a; axi.awlen = len; axi.awsize = sz; axi.awburst = bt; axi.awid = id;
        axi.awvalid = 1'b1;
    endtask

    task automatic set_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bt, input logic [3:0] id);
        axi.araddr = a; axi.arlen = len; axi.arsize = sz; axi.arburst = bt; axi.arid = id;
        axi.arvalid = 1'b1;
    endtask

    task automatic aw_hs();
        int cyc = 0;
        #1;
        while (!axi.awready && cyc < c_LIMIT) begin @(negedge clk); #1; cyc++; end
        chk("awready_timeout", 64'(cyc < c_LIMIT), 64'd1);
        @(negedge clk);
        axi.awvalid = 1'b0;
    endtask

    task automatic ar_hs();
        int cyc = 0;
        #1;
        while (!axi.arready && cyc < c_LIMIT) begin @(negedge clk); #1; cyc++; end
        chk("arready_timeout", 64'(cyc < c_LIMIT), 64'd1);
        @(negedge clk);
        axi.arvalid = 1'b0;
    endtask

    task automatic w_beats(input int n);
        for (int i = 0; i < n; i++) begin
            int cyc = 0;
            axi.wvalid = 1'b1; axi.wdata = wd[i]; axi.wstrb = ws[i]; axi.wlast = wl[i];
            #1;
            while (!axi.wready && cyc < c_LIMIT) begin @(negedge clk); #1; cyc++; end
            if (cyc >= c_LIMIT) chk("wready_timeout", 64'(cyc), 64'(c_LIMIT - 1));
            @(negedge clk);
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
    endtask

    task automatic get_b(input int dly);
        int cyc = 0;
        #1;
        while (!axi.bvalid && cyc < c_LIMIT) begin @(negedge clk); #1; cyc++; end
        chk("bvalid_timeout", 64'(cyc < c_LIMIT), 64'd1);
        b_wait  = cyc;
        bresp_v = axi.bresp;
        bid_v   = axi.bid;
        for (int k = 0; k < dly; k++) begin
            @(negedge clk); #1;
            chk("b_stable", {axi.bvalid, axi.bresp, axi.bid}, {1'b1, bresp_v, bid_v});
        end
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
    endtask

    task automatic get_r(input int n, input int max_dly);
        for (int i = 0; i < n; i++) begin
            int cyc = 0;
            int dly = (max_dly == 0) ? 0 : int'($urandom_range(0, max_dly));
            #1;
            while (!axi.rvalid && cyc < c_LIMIT) begin @(negedge clk); #1; cyc++; end
            if (cyc >= c_LIMIT) chk("rvalid_timeout", 64'(cyc), 64'(c_LIMIT - 1));
            if (i == 0) r_wait = cyc;
            rdv[i] = axi.rdata; rrv[i] = axi.rresp; rlv[i] = axi.rlast; rid_v = axi.rid;
            for (int k = 0; k < dly; k++) begin
                @(negedge clk); #1;
                chk("r_stable", {axi.rvalid, axi.rdata, axi.rresp, axi.rlast, axi.rid},
                    {1'b1, rdv[i], rrv[i], rlv[i], rid_v});
            end
            axi.rready = 1'b1;
            @(negedge clk);
            axi.rready = 1'b0;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bt, input logic [3:0] id, input int dly);
        set_aw(a, len, sz, bt, id);
        aw_hs();
        w_beats(int'(len) + 1);
        get_b(dly);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt,
                           input logic [3:0] id, input int max_dly);
        set_ar(a, len, 3'd2, bt, id);
        ar_hs();
        get_r(int'(len) + 1, max_dly);
    endtask

    initial begin
        axi.awvalid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0; axi.awid = 0;
        axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 0;
        axi.arvalid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0; axi.arid = 0;
        axi.rready = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctl", 64'(ctl_outs), 64'd0);
        chk("reset_rdata", 64'(axi.rdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write then read, with latency checks
        fill(1, 32'hDEADBEEF);
        do_write(32'h10, 8'd0, 3'd2, c_INCR, 4'd3, 0);
        chk("single_bresp", 64'(bresp_v), 64'd0);
        chk("single_bid", 64'(bid_v), 64'd3);
        chk("single_b_latency", 64'(b_wait), 64'd0);
        do_read(32'h10, 8'd0, c_INCR, 4'd5, 0);
        chk("single_rdata", 64'(rdv[0]), 64'hDEADBEEF);
        chk("single_rresp", 64'(rrv[0]), 64'd0);
        chk("single_rlast", 64'(rlv[0]), 64'd1);
        chk("single_rid", 64'(rid_v), 64'd5);
        chk("single_r_latency", 64'(r_wait), 64'd1);

        // INCR burst followed by a byte-strobed overwrite of word 1
        fill(4, 32'd1);
        do_write(32'h0, 8'd3, 3'd2, c_INCR, 4'd1, 1);
        chk("incr_bresp", 64'(bresp_v), 64'd0);
        fill(1, 32'hFF);
        ws[0] = 4'b0001;
        do_write(32'h4, 8'd0, 3'd2, c_INCR, 4'd1, 0);
        chk("strb_bresp", 64'(bresp_v), 64'd0);
        do_read(32'h0, 8'd3, c_INCR, 4'd2, 2);
        chk("incr_rd0", 64'(rdv[0]), 64'd1);
        chk("incr_rd1", 64'(rdv[1]), 64'hFF);
        chk("incr_rd2", 64'(rdv[2]), 64'd3);
        chk("incr_rd3", 64'(rdv[3]), 64'd4);
        chk("incr_rlast", 64'({rlv[0], rlv[1], rlv[2], rlv[3]}), 64'b0001);

        // WRAP read of 4 beats starting mid-block: words 2,3,0,1
        do_read(32'h8, 8'd3, c_WRAP, 4'd4, 1);
        chk("wrap_rd0", 64'(rdv[0]), 64'd3);
        chk("wrap_rd1", 64'(rdv[1]), 64'd4);
        chk("wrap_rd2", 64'(rdv[2]), 64'd1);
        chk("wrap_rd3", 64'(rdv[3]), 64'hFF);
        chk("wrap_rlast", 64'({rlv[0], rlv[1], rlv[2], rlv[3]}), 64'b0001);

        // Out-of-range read
        do_read(32'h1000, 8'd0, c_INCR, 4'd6, 0);
        chk("oor_rresp", 64'(rrv[0]), 64'd3);
        chk("oor_rdata", 64'(rdv[0]), 64'd0);

        // Wrong size: SLVERR and memory untouched
        fill(1, 32'h12345678);
        do_write(32'h0, 8'd0, 3'd1, c_INCR, 4'd2, 0);
        chk("badsize_bresp", 64'(bresp_v), 64'd2);
        do_read(32'h0, 8'd0, c_INCR, 4'd2, 0);
        chk("badsize_mem", 64'(rdv[0]), 64'd1);

        // Early wlast on beat 1 of a 3-beat burst
        fill(3, 32'h55);
        wl[0] = 1'b0; wl[1] = 1'b1; wl[2] = 1'b0;
        do_write(32'h20, 8'd2, 3'd2, c_INCR, 4'd2, 0);
        chk("wlast_bresp", 64'(bresp_v), 64'd2);

        // Arbitration after reset: write first, then alternate
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill(1, 32'hA5A50001);
        set_aw(32'h40, 8'd0, 3'd2, c_INCR, 4'd7);
        set_ar(32'h10, 8'd0, 3'd2, c_INCR, 4'd9);
        #1;
        chk("tie1_ready", 64'({axi.awready, axi.arready}), 64'b10);
        @(negedge clk);
        axi.awvalid = 1'b0;
        #1;
        chk("ar_blocked", 64'(axi.arready), 64'd0);
        w_beats(1);
        get_b(int'($urandom_range(1, 3)));
        chk("tie1_bresp", 64'(bresp_v), 64'd0);
        chk("tie1_bid", 64'(bid_v), 64'd7);
        set_aw(32'h44, 8'd0, 3'd2, c_INCR, 4'd8);
        #1;
        chk("tie2_ready", 64'({axi.awready, axi.arready}), 64'b01);
        @(negedge clk);
        axi.arvalid = 1'b0;
        get_r(1, 3);
        chk("tie2_rdata", 64'(rdv[0]), 64'hDEADBEEF);
        chk("tie2_rid", 64'(rid_v), 64'd9);
        aw_hs();
        fill(1, 32'hA5A50002);
        w_beats(1);
        get_b(int'($urandom_range(1, 3)));
        chk("tie3_bid", 64'(bid_v), 64'd8);
        do_read(32'h40, 8'd1, c_INCR, 4'd1, 3);
        chk("tie_mem0", 64'(rdv[0]), 64'hA5A50001);
        chk("tie_mem1", 64'(rdv[1]), 64'hA5A50002);

        // Reset during beat 2 of an 8-beat INCR write
        fill(8, 32'h100);
        set_aw(32'h80, 8'd7, 3'd2, c_INCR, 4'd3);
        aw_hs();
        w_beats(2);
        axi.wvalid = 1'b1; axi.wdata = wd[2]; axi.wstrb = 4'hF; axi.wlast = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_ctl", 64'(ctl_outs), 64'd0);
        chk("midrst_rdata", 64'(axi.rdata), 64'd0);
        axi.wvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        do_read(32'h80, 8'd1, c_INCR, 4'd2, 0);
        chk("midrst_mem0", 64'(rdv[0]), 64'h100);
        chk("midrst_mem1", 64'(rdv[1]), 64'h101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/armleosoc_axi_bram.md
# armleosoc_axi_bram

AXI4 slave that terminates the single host port produced by `armleosoc_axi_arbiter` into an on-chip synchronous single-port word memory. It sits directly downstream of the arbiter and gives the arbitrated hosts a shared scratchpad/boot RAM. It serves one transaction at a time, with FIXED, INCR and WRAP bursts, byte strobes and per-beat range checking.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 32: data width; a power of two, 32 or wider.
- `ID_WIDTH`, 4: AXI ID width; must match the arbiter's output ID width.
- `DEPTH`, 1024: memory depth in words; a power of two.
- `BASE_ADDR`, 0: byte address of word 0; aligned to `DEPTH*DATA_WIDTH/8`.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `axi_aw*` (AW channel):
  - `awvalid` in 1, `awready` out 1
  - `awaddr` in ADDR_WIDTH, `awlen` in 8, `awsize` in 3, `awburst` in 2, `awid` in ID_WIDTH
- `axi_w*` (W channel): `wvalid` in 1, `wready` out 1, `wdata` in DATA_WIDTH, `wstrb` in DATA_WIDTH/8, `wlast` in 1.
- `axi_b*` (B channel): `bvalid` out 1, `bready` in 1, `bresp` out 2, `bid` out ID_WIDTH.
- `axi_ar*` (AR channel): `arvalid`, `arready`, `araddr`, `arlen`, `arsize`, `arburst`, `arid`, with the same widths and directions as AW.
- `axi_r*` (R channel): `rvalid` out 1, `rready` in 1, `rdata` out DATA_WIDTH, `rresp` out 2, `rid` out ID_WIDTH, `rlast` out 1.

## Operation
- **FSM states:** IDLE, WDATA, WRESP, RFETCH, RDATA. There is a 1-bit `last_was_write` flag.
- **IDLE, single request:**
  - If only `awvalid` is high, assert `awready`, capture AW on the handshake, then go to WDATA.
  - If only `arvalid` is high, assert `arready`, capture AR on the handshake, then go to RFETCH.
- **IDLE, both requests:** if `awvalid` and `arvalid` are both high, serve the opposite of `last_was_write`. Only one ready is high in any cycle.
- **Captured state:** each accepted burst captures:
  - current address, beat counter = `len`, burst type, ID;
  - wrap mask = `(len+1)*BYTES-1`, where BYTES = DATA_WIDTH/8;
  - `err` = SLVERR (2'b10) if size != log2(BYTES), or burst == 3, or (burst == WRAP and len not in {1,3,7,15}); otherwise OKAY.
- **Address update after each beat:**
  - FIXED: the address is unchanged.
  - INCR: addr += BYTES. The address is not checked against the 4 KB boundary.
  - WRAP: addr = (addr & ~mask) | ((addr + BYTES) & mask).
- **Per-beat range check:** the word index is `(addr - BASE_ADDR) >> log2(BYTES)`. If the address is outside [BASE_ADDR, BASE_ADDR + DEPTH*BYTES), the beat is DECERR (2'b11).
- **Unaligned addresses:** the low address bits are ignored for indexing, and the beat still uses the full word.
- **WDATA:**
  - `wready` = 1.
  - Each W handshake writes the bytes enabled by `wstrb` in the same edge, but only if the burst has no error and the beat is in range.
  - The counter decrements on each beat. On the beat where the counter == 0, go to WRESP.
  - `wlast` is ignored for sequencing. A `wlast` mismatch against the counter forces `bresp` = SLVERR unless a worse response is already pending.
- **WRESP:**
  - `bvalid` = 1, `bid` = captured ID.
  - `bresp` = the worst response of the burst, with DECERR > SLVERR > OKAY.
  - On `bready`, go to IDLE and set `last_was_write` = 1.
- **RFETCH:** issue the memory read for the current address, then go to RDATA.
- **RDATA:**
  - `rvalid` = 1 and `rid` = captured ID.
  - `rdata` = memory word, or 0 if the beat is an error.
  - `rresp` = per-beat response.
  - `rlast` = (counter == 0).
  - On `rready`: if last, go to IDLE and set `last_was_write` = 0. Otherwise advance the address, decrement the counter and go to RFETCH.
- **Memory:** an inferred reg array with a registered read port. Memory contents are not reset.

## Timing
- **Reset values:** all outputs are 0. The FSM is in IDLE and `last_was_write` = 0, so writes win the first tie.
- **Reset mid-burst:** the in-flight burst is abandoned. Writes already committed remain in memory, and no B or R response is emitted for the burst.
- **Write latency:** AW handshake at cycle 0, `wready` high from cycle 1, at most 1 beat per cycle. `bvalid` rises the cycle after the last W handshake.
- **Read latency:** AR handshake at cycle 0, RFETCH at cycle 1, `rvalid` at cycle 2. The steady state is 1 beat per 2 cycles while `rready` is held high.
- **AXI stability:** `rvalid` and `bvalid`, once high, hold their payload stable until the handshake completes.
- **Blocked address channels:** no AW/AR acceptance outside IDLE; `awready` and `arready` are 0 in all other states.
- **Channel independence:** no ready depends combinationally on the same channel's valid except in IDLE.

## Test plan
- **Single write then read:** AW addr 0x10, len 0, `wdata` 0xDEADBEEF, `wstrb` 0xF, then AR 0x10 → `bresp` 0 and `rdata` 0xDEADBEEF. `rvalid` rises 2 cycles after the AR handshake, and `rlast` = 1.
- **INCR with strobes:** INCR len 3 at 0x0, data 1..4, then a single write to word 1 with `wstrb` 0b0001 and data 0xFF → reading the 4 beats returns 1, 0x000000FF, 3, 4.
- **WRAP burst:** WRAP len 3 read at 0x8 → words are returned in order 2, 3, 0, 1, and `rlast` is high only on the 4th beat.
- **Error responses:**
  - Read at BASE_ADDR + DEPTH*4 → `rresp` 3 and `rdata` 0.
  - `awsize` 1 → `bresp` 2 and memory unchanged.
  - `wlast` early on beat 1 of len 2 → `bresp` 2.
- **Simultaneous AW/AR after reset:** write is served first, then read. Repeat with both valid → write and read alternate. Random `bready`/`rready` backpressure holds the payloads stable.
- **Reset mid-burst:** deassert `rst_n` during beat 2 of an INCR len 7 write → FSM returns to IDLE, all outputs are 0, and beats 0–1 persist in memory.
